// File: rtl/reg_share_pkg.sv
// Shared types and default sizing for the register-sharing arbiter.
package reg_share_pkg;

  localparam int unsigned N_REQ_DEFAULT = 4;
  localparam int unsigned DW_DEFAULT    = 8;
  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StCheck
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  logic [IW:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!valid_o && req_i[cand[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter serialising writes to one shared enable-gated register,
// with read-back check of every write.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*DW-1:0]      wdata_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [N_REQ-1:0]         ack_o,
  output logic                     reg_en_o,
  output logic [DW-1:0]            reg_d_o,
  input  logic [DW-1:0]            reg_q_i,
  input  logic                     reg_zero_i,
  output logic [DW-1:0]            rd_data_o,
  output logic                     rd_zero_o,
  output logic                     err_o,
  output logic [$clog2(N_REQ)-1:0] owner_o,
  output logic [CNT_W-1:0]         wr_count_o
);

  localparam int unsigned IW = $clog2(N_REQ);

  state_e         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  sel_q, sel_d;
  logic [DW-1:0]  wbuf_q, wbuf_d;
  logic [DW-1:0]  rd_data_q, rd_data_d;
  logic           rd_zero_q, rd_zero_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    wbuf_d    = wbuf_q;
    rd_data_d = rd_data_q;
    rd_zero_d = rd_zero_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          state_d = StWrite;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
              wbuf_d = wdata_i[i*DW +: DW];
            end
          end
        end
      end
      StWrite: state_d = StCheck;
      StCheck: begin
        rd_data_d = reg_q_i;
        rd_zero_d = reg_zero_i;
        owner_d   = sel_q;
        ptr_d     = (sel_q == IW'(N_REQ - 1)) ? '0 : sel_q + IW'(1);
        cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes come only from registered state so requesters see no comb path.
  always_comb begin
    gnt_o    = '0;
    ack_o    = '0;
    reg_en_o = 1'b0;
    reg_d_o  = '0;
    err_o    = 1'b0;
    if (state_q == StWrite) begin
      gnt_o    = N_REQ'(1) << sel_q;
      reg_en_o = 1'b1;
      reg_d_o  = wbuf_q;
    end
    if (state_q == StCheck) begin
      ack_o = N_REQ'(1) << sel_q;
      err_o = (reg_q_i != wbuf_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      sel_q     <= '0;
      wbuf_q    <= '0;
      rd_data_q <= '0;
      rd_zero_q <= 1'b0;
      owner_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      wbuf_q    <= wbuf_d;
      rd_data_q <= rd_data_d;
      rd_zero_q <= rd_zero_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_zero_o  = rd_zero_q;
  assign owner_o    = owner_q;
  assign wr_count_o = cnt_q;

endmodule
